// File: rtl/pool_row_pairer_pkg.sv
// Shared constants and state encodings for the pool_PE row-pair feeder.
// Every file of the block takes its widths from here.
package pool_row_pairer_pkg;

  localparam int POOL_FEATURE_WIDTH = 16;
  localparam int POOL_MAX_COL       = 416;
  localparam int POOL_DIM_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAIR = 2'd2,
    ST_DONE = 2'd3
  } pool_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pool_row_pairer_if.sv
// Pixel stream in, vertical pixel pair (plus pool_PE result strobe) out.
interface pool_row_pairer_if
  import pool_row_pairer_pkg::*;
#(
  parameter int FW = POOL_FEATURE_WIDTH
);
  logic                 in_valid;
  logic signed [FW-1:0] in_data;
  logic signed [FW-1:0] x1_;
  logic signed [FW-1:0] x2_;
  logic                 pulse;
  logic                 pe_out_valid;

  modport master (output in_valid, in_data, input x1_, x2_, pulse, pe_out_valid);
  modport slave  (input in_valid, in_data, output x1_, x2_, pulse, pe_out_valid);
endinterface

// File: rtl/pool_line_buffer.sv
// Single-port line buffer holding one even row; written in FILL, read in PAIR.
// Read data is registered and holds while the port is idle or writing.
module pool_line_buffer
  import pool_row_pairer_pkg::*;
#(
  parameter int WIDTH = POOL_FEATURE_WIDTH,
  parameter int DEPTH = POOL_MAX_COL,
  parameter int AW    = addr_w(DEPTH)
)(
  input  logic                    DSP_clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] wdata,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the RAM maps onto block memory.
  always_ff @(posedge DSP_clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/pool_row_pairer.sv
// Buffers each even row and streams (upper, lower) pixel pairs to pool_PE
// during the following odd row; also flags when pool_PE.out is fresh.
module pool_row_pairer
  import pool_row_pairer_pkg::*;
#(
  parameter int FEATURE_WIDTH = POOL_FEATURE_WIDTH,
  parameter int MAX_COL       = POOL_MAX_COL,
  parameter int DIM_W         = POOL_DIM_W
)(
  input  logic             DSP_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] col_num,
  input  logic [DIM_W-1:0] row_num,
  pool_row_pairer_if.slave pix,
  output logic             busy,
  output logic             done
);

  localparam int AW     = addr_w(MAX_COL);
  localparam int STAGES = 2;

  pool_state_e state;
  logic [DIM_W-1:0] col, row, col_num_q, row_num_q;
  logic [STAGES:1]  vld_pipe;
  logic signed [FEATURE_WIDTH-1:0] rd_q, x1_hold, x2_q;

  logic in_frame, pair_fire, col_last, row_last;
  assign in_frame  = (state == ST_FILL) || (state == ST_PAIR);
  assign pair_fire = pix.in_valid && (state == ST_PAIR);
  assign col_last  = (col == col_num_q - DIM_W'(1));
  assign row_last  = (row == row_num_q - DIM_W'(1));

  pool_line_buffer #(
    .WIDTH (FEATURE_WIDTH),
    .DEPTH (MAX_COL),
    .AW    (AW)
  ) u_buf (
    .DSP_clk (DSP_clk),
    .en      (pix.in_valid && in_frame),
    .we      (state == ST_FILL),
    .addr    (col[AW-1:0]),
    .wdata   (pix.in_data),
    .rdata   (rd_q)
  );

  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      col_num_q <= '0;
      row_num_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          col_num_q <= col_num;
          row_num_q <= row_num;
          col       <= '0;
          row       <= '0;
          if (col_num == '0 || row_num == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_FILL;
            busy  <= 1'b1;
          end
        end
        ST_FILL, ST_PAIR: if (pix.in_valid) begin
          if (col_last) begin
            col <= '0;
            row <= row + DIM_W'(1);
            // Last row of the frame ends from either state; an odd final row
            // is swallowed in FILL and never paired.
            if (row_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= (state == ST_FILL) ? ST_PAIR : ST_FILL;
            end
          end else begin
            col <= col + DIM_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lower pixel is registered alongside the RAM read so both land at t+1;
  // vld_pipe[1] is pulse, vld_pipe[2] marks pool_PE's registered result.
  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x2_q     <= '0;
      x1_hold  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pair_fire};
      if (pair_fire)   x2_q    <= pix.in_data;
      if (vld_pipe[1]) x1_hold <= rd_q;
    end
  end

  assign pix.x1_          = vld_pipe[1] ? rd_q : x1_hold;
  assign pix.x2_          = x2_q;
  assign pix.pulse        = vld_pipe[1];
  assign pix.pe_out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_pool_row_pairer.sv
// Scoreboard bench for pool_row_pairer: stimulus pushes expected pairs and
// pool_PE maxima; a negedge monitor pops and compares them.
module tb_pool_row_pairer;
  import pool_row_pairer_pkg::*;

  localparam int FW = POOL_FEATURE_WIDTH;
  localparam int MC = POOL_MAX_COL;
  localparam int DW = POOL_DIM_W;

  logic          DSP_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic [DW-1:0] col_num = '0;
  logic [DW-1:0] row_num = '0;
  logic          busy, done;

  pool_row_pairer_if #(.FW(FW)) pix();

  pool_row_pairer #(.FEATURE_WIDTH(FW), .MAX_COL(MC), .DIM_W(DW)) dut (
    .DSP_clk (DSP_clk),
    .rst_n   (rst_n),
    .start   (start),
    .col_num (col_num),
    .row_num (row_num),
    .pix     (pix),
    .busy    (busy),
    .done    (done)
  );

  always #5 DSP_clk = ~DSP_clk;

  typedef struct { int x1; int x2; int cyc; } pair_t;
  pair_t pq[$];
  int    peq[$];
  int    px[$];

  int checks = 0, failures = 0;
  int cyc = 0, pulse_cnt = 0, done_cnt = 0, done_cyc = -1, last_beat = -1;
  bit hold_chk = 1'b0;
  logic signed [FW-1:0] pe_out;
  logic signed [FW-1:0] last_x1 = '0, last_x2 = '0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference pool_PE: registers the signed max on each pulse.
  always @(posedge DSP_clk) begin
    cyc <= cyc + 1;
    if (pix.pulse) pe_out <= (pix.x1_ > pix.x2_) ? pix.x1_ : pix.x2_;
  end

  always @(negedge DSP_clk) begin
    if (rst_n) begin
      if (pix.pulse) begin
        pulse_cnt++;
        if (pq.size() == 0) chk("pulse_unexpected", pix.pulse, 0);
        else begin
          pair_t p;
          p = pq.pop_front();
          chk("x1", pix.x1_, p.x1);
          chk("x2", pix.x2_, p.x2);
          chk("pulse_cyc", cyc, p.cyc);
        end
        last_x1 = pix.x1_;
        last_x2 = pix.x2_;
      end else if (hold_chk) begin
        chk("x1_hold", pix.x1_, last_x1);
        chk("x2_hold", pix.x2_, last_x2);
      end
      if (pix.pe_out_valid) begin
        if (peq.size() == 0) chk("pe_unexpected", pix.pe_out_valid, 0);
        else chk("pe_out", pe_out, peq.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge DSP_clk); #1; end
  endtask

  task automatic do_start(input int cols, input int rows);
    col_num = DW'(cols);
    row_num = DW'(rows);
    start   = 1'b1;
    @(posedge DSP_clk); #1;
    start   = 1'b0;
  endtask

  // Drives px[] as one frame; with model set, each odd-row beat expects the
  // pixel one row up paired with itself, one cycle after the beat.
  task automatic run_frame(input int cols, input int gap, input bit model, input int poke_at);
    for (int i = 0; i < px.size(); i++) begin
      int r, bc, up;
      r  = i / cols;
      bc = cyc;
      if (model && (r % 2 == 1)) begin
        up = px[i - cols];
        pq.push_back('{up, px[i], bc + 1});
        peq.push_back((up > px[i]) ? up : px[i]);
      end
      if (i == poke_at) begin
        start = 1'b1; col_num = DW'(1); row_num = DW'(1);
      end
      pix.in_valid = 1'b1;
      pix.in_data  = FW'(px[i]);
      @(posedge DSP_clk); #1;
      pix.in_valid = 1'b0;
      start        = 1'b0;
      last_beat    = bc;
      repeat (gap) begin @(posedge DSP_clk); #1; end
    end
  endtask

  task automatic drained(input string tag);
    chk({tag, "_pairs_left"}, pq.size(), 0);
    chk({tag, "_pe_left"}, peq.size(), 0);
  endtask

  initial begin
    int s, p0, d0;
    pix.in_valid = 1'b0;
    pix.in_data  = '0;

    #12;
    chk("rst_x1", pix.x1_, 0);
    chk("rst_x2", pix.x2_, 0);
    chk("rst_pulse", pix.pulse, 0);
    chk("rst_pe_valid", pix.pe_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #11 rst_n = 1'b1;
    idle(2);

    // 4x2 frame, hand-computed pairs and maxima
    px = '{1, -5, 7, 0, 3, -2, -9, 0};
    do_start(4, 2);
    s  = cyc;
    d0 = done_cnt;
    pq.push_back('{1, 3, s + 5});
    pq.push_back('{-5, -2, s + 6});
    pq.push_back('{7, -9, s + 7});
    pq.push_back('{0, 0, s + 8});
    peq = '{3, -2, 7, 0};
    chk("t1_busy", busy, 1);
    run_frame(4, 0, 1'b0, -1);
    idle(4);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_done_cyc", done_cyc, s + 8);
    drained("t1");

    // 3 wide, 5 rows: last row swallowed
    px.delete();
    for (int i = 1; i <= 15; i++) px.push_back((i % 2) ? -(i * 3) : i * 7);
    p0 = pulse_cnt; d0 = done_cnt;
    do_start(3, 5);
    run_frame(3, 0, 1'b1, -1);
    idle(4);
    chk("t2_pulses", pulse_cnt - p0, 6);
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_done_cyc", done_cyc, last_beat + 1);
    drained("t2");

    // gapped 2x2 with output hold checking
    px = '{-4, 6, 10, -12};
    p0 = pulse_cnt;
    hold_chk = 1'b1;
    do_start(2, 2);
    run_frame(2, 1, 1'b1, -1);
    idle(3);
    hold_chk = 1'b0;
    chk("t3_pulses", pulse_cnt - p0, 2);
    chk("t3_done_cyc", done_cyc, last_beat + 1);
    drained("t3");

    // zero width frame, then in_valid while idle
    p0 = pulse_cnt; d0 = done_cnt;
    do_start(0, 3);
    chk("t4_done", done, 1);
    chk("t4_busy0", busy, 0);
    idle(1);
    chk("t4_done_end", done, 0);
    chk("t4_busy1", busy, 0);
    for (int i = 0; i < 3; i++) begin
      pix.in_valid = 1'b1; pix.in_data = FW'(50 + i);
      idle(1);
    end
    pix.in_valid = 1'b0;
    idle(3);
    chk("t4_pulses", pulse_cnt - p0, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // start while busy must be ignored
    px = '{5, -1, 2, 8};
    p0 = pulse_cnt; d0 = done_cnt;
    do_start(2, 2);
    run_frame(2, 0, 1'b1, 2);
    idle(4);
    chk("t5_pulses", pulse_cnt - p0, 2);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_done_cyc", done_cyc, last_beat + 1);
    drained("t5");

    // reset after two of four PAIR beats
    px = '{4, 3, 2, 1, 9, -9};
    do_start(4, 2);
    run_frame(4, 0, 1'b1, -1);
    rst_n = 1'b0;
    #1;
    chk("t6_x1", pix.x1_, 0);
    chk("t6_x2", pix.x2_, 0);
    chk("t6_pulse", pix.pulse, 0);
    chk("t6_pe_valid", pix.pe_out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    pq.delete(); peq.delete();
    idle(2);
    #2 rst_n = 1'b1;
    idle(2);
    px = '{-7, -3, -8, 100};
    p0 = pulse_cnt; d0 = done_cnt;
    do_start(2, 2);
    run_frame(2, 0, 1'b1, -1);
    idle(4);
    chk("t6_pulses", pulse_cnt - p0, 2);
    chk("t6_done_cnt", done_cnt - d0, 1);
    drained("t6");

    // full width, signed extremes
    px.delete();
    for (int i = 0; i < 2 * MC; i++) begin
      bit hi;
      hi = ((i % MC) % 2 == 1) ^ (i >= MC);
      px.push_back(hi ? 32767 : -32768);
    end
    p0 = pulse_cnt; d0 = done_cnt;
    do_start(MC, 2);
    run_frame(MC, 0, 1'b1, -1);
    idle(4);
    chk("t7_pulses", pulse_cnt - p0, MC);
    chk("t7_done_cnt", done_cnt - d0, 1);
    chk("t7_last_max", pe_out, 32767);
    drained("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
